mux_n_pipe: RTL and testbench
=============================

# mux_n_pipe

Parametrised, pipelined N:1 word multiplexer with valid/ready handshaking on both sides. It replaces fixed-width combinational select muxes on datapath paths that cross a stage boundary, such as writeback select and forwarding select. The block registers the selected word together with its source index and a select-range error flag. A two-entry skid stage lets it sustain one transfer per cycle under downstream back-pressure. Out-of-range selects are defined, never latched, and counted.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each input word and of out_data
- NUM_INPUTS, 3, number of input words; legal range 2..16
- SEL_WIDTH, derived as clog2(NUM_INPUTS) with a minimum of 1; localparam, not overridable
- ERR_CNT_WIDTH, 16, width of the saturating error counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  NUM_INPUTS*DATA_WIDTH  packed inputs; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- in_sel  in  SEL_WIDTH  select index
- in_valid  in  1  upstream offers in_data/in_sel
- in_ready  out  1  block can accept a transfer this cycle
- out_data  out  DATA_WIDTH  selected word
- out_src  out  SEL_WIDTH  in_sel captured with this word
- out_err  out  1  captured in_sel was >= NUM_INPUTS
- out_valid  out  1  output word is valid
- out_ready  in  1  downstream accepts
- err_count  out  ERR_CNT_WIDTH  number of accepted out-of-range selects, saturating

## Operation
- Input transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- On an input transfer the block captures an entry {word, sel, err}:
  - If in_sel < NUM_INPUTS: word = in_data word in_sel, err = 0.
  - Otherwise: word = 0, err = 1. The entry still propagates; it is never dropped.
- Storage is a main output register plus one skid register.
  - The output ports always show the main register.
  - The skid register fills only when an input transfer occurs while the main register is valid and out_ready = 0.
- Occupancy states:
  - EMPTY (0 entries)
  - ONE (main valid)
  - FULL (main and skid valid)
- Transitions (in = input transfer, out = output transfer):
  - EMPTY + in -> ONE
  - ONE + in + out -> ONE (main replaced by the new entry)
  - ONE + in, no out -> FULL
  - ONE + out, no in -> EMPTY
  - FULL + out -> ONE (skid moves into main)
  - FULL never accepts: in_ready = 0
- in_ready = (state != FULL). It is a registered signal and does not depend combinationally on out_ready.
- err_count increments by 1 on each input transfer with err = 1. It holds at all-ones.
- Ordering is strictly FIFO. in_data and in_sel are sampled only on the transfer edge.

## Timing
- Reset (asynchronous on rst_n low, synchronous release):
  - state = EMPTY, out_valid = 0, in_ready = 1
  - out_data = 0, out_src = 0, out_err = 0, err_count = 0
- Latency: an input transfer at edge N makes out_valid = 1 after edge N, with the captured data.
- Throughput: one transfer per cycle when out_ready is held at 1.
- With back-pressure, at most 2 entries are held. in_ready drops the cycle after the skid fills.
- out_data, out_src and out_err must not change while out_valid && !out_ready.
- An input transfer and an output transfer in the same cycle are both honoured in every state that permits them.
- Reset asserted mid-operation discards all entries immediately. err_count clears.

## Structure
- Package mux_n_pkg:
  - clog2-based SEL_WIDTH helper function
  - entry struct typedef {data, src, err}
  - state enum {EMPTY, ONE, FULL}
  - NUM_INPUTS legality constants
- Sub-module mux_skid_buf: holds the two-entry storage, state and handshake, and is generic over entry width.
- The top level instantiates the select/decode logic, the err_count counter and one mux_skid_buf.

## Test plan
- After reset, with DATA_WIDTH=32 and NUM_INPUTS=3:
  - Drive in_data words {0xAAAA0000, 0x1111BBBB, 0xCCCC2222}, in_sel=2, out_ready=1.
  - Required: out_data=0xCCCC2222, out_src=2, out_err=0, one cycle after the transfer.
- Drive in_sel=3 with NUM_INPUTS=3.
  - Required: out_data=0, out_err=1, err_count=1.
  - Repeat 0x10000 times: err_count saturates at 0xFFFF.
- Hold out_ready=0 and offer 3 back-to-back entries with sel 0, 1, 2.
  - Required: 2 entries accepted, then in_ready=0, and out_data stays stable.
  - Release out_ready: outputs appear in order 0, 1, 2.
- Stream 100 random entries with random out_ready.
  - Required: outputs match a reference FIFO model exactly, with no loss or duplication.
- Reach FULL, then pulse rst_n low mid-cycle.
  - Required: out_valid=0 and in_ready=1 immediately, err_count=0, and no stale entry after release.
- Run with NUM_INPUTS=16 and DATA_WIDTH=8, sweeping sel 0..15.
  - Required: each output equals input word k and out_err is never set.

Source files
------------

// File: rtl/mux_n_pkg.sv
// Shared types and constants for the pipelined N:1 word multiplexer.
// The skid buffer is generic over entry width; the top packs {err, src, data} into it.
package mux_n_pkg;

    localparam int MIN_INPUTS     = 2;
    localparam int MAX_INPUTS     = 16;
    localparam int MAX_DATA_WIDTH = 64;
    localparam int MAX_SEL_WIDTH  = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Widest entry layout; instances pack the same fields at their exact widths.
    typedef struct packed {
        logic [MAX_DATA_WIDTH-1:0] data;
        logic [MAX_SEL_WIDTH-1:0]  src;
        logic                      err;
    } entry_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry output stage (main + skid) with valid/ready on both sides.
// Outputs always show the main register; in_ready decodes from registered state only.
module mux_skid_buf
    import mux_n_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_entry_i,
    input  logic         in_valid_i,
    output logic [W-1:0] out_entry_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [1:0]   state_o
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    state_t       state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire;
    logic         out_fire;

    assign in_fire     = in_valid_i && (state_q != FULL);
    assign out_fire    = (state_q != EMPTY) && out_ready_i;
    assign out_entry_o = main_q;
    assign out_valid_o = (state_q != EMPTY);
    assign state_o     = state_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_entry_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_entry_i;
                end else if (in_fire) begin
                    skid_d  = in_entry_i;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// Pipelined N:1 word mux: selects a word, tags it with its source index and a
// range-error flag, and hands it to a two-entry skid stage. Bad selects are counted.
module mux_n_pipe
    import mux_n_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int NUM_INPUTS    = 3,
    parameter  int ERR_CNT_WIDTH = 16,
    localparam int SEL_WIDTH     = sel_width(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]             in_sel,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SEL_WIDTH-1:0]             out_src,
    output logic                             out_err,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ERR_CNT_WIDTH-1:0]         err_count
);

    localparam int ENTRY_W = DATA_WIDTH + SEL_WIDTH + 1;

    if (NUM_INPUTS < MIN_INPUTS || NUM_INPUTS > MAX_INPUTS) begin : g_bad_num_inputs
        $error("mux_n_pipe: NUM_INPUTS must be in 2..16");
    end

    logic [DATA_WIDTH-1:0]    sel_word;
    logic                     sel_err;
    logic [ENTRY_W-1:0]       in_entry;
    logic [ENTRY_W-1:0]       out_entry;
    logic [1:0]               buf_state;
    logic                     in_fire;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    // Match against each legal index so an out-of-range select never indexes past in_data.
    always_comb begin
        sel_word = '0;
        sel_err  = 1'b1;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (in_sel == SEL_WIDTH'(k)) begin
                sel_word = in_data[k*DATA_WIDTH +: DATA_WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    assign in_entry = {sel_err, in_sel, sel_word};
    assign in_ready = (buf_state != FULL);
    assign in_fire  = in_valid && in_ready;

    mux_skid_buf #(.W(ENTRY_W)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_entry_i  (in_entry),
        .in_valid_i  (in_valid),
        .out_entry_o (out_entry),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .state_o     (buf_state)
    );

    assign {out_err, out_src, out_data} = out_entry;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (in_fire && sel_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: a 32-bit/3-input instance and an 8-bit/16-input instance.
// Inputs change and outputs are sampled on the falling edge.
module tb_mux_n_pipe;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: DATA_WIDTH=32, NUM_INPUTS=3 ----------------
    logic [95:0] a_in_data;
    logic [1:0]  a_in_sel;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [31:0] a_out_data;
    logic [1:0]  a_out_src;
    logic        a_out_err;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [15:0] a_err_count;

    mux_n_pipe #(.DATA_WIDTH(32), .NUM_INPUTS(3), .ERR_CNT_WIDTH(16)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in_data),
        .in_sel    (a_in_sel),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_src   (a_out_src),
        .out_err   (a_out_err),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .err_count (a_err_count)
    );

    // ---------------- instance B: DATA_WIDTH=8, NUM_INPUTS=16 ----------------
    logic [127:0] b_in_data;
    logic [3:0]   b_in_sel;
    logic         b_in_valid;
    logic         b_in_ready;
    logic [7:0]   b_out_data;
    logic [3:0]   b_out_src;
    logic         b_out_err;
    logic         b_out_valid;
    logic         b_out_ready;
    logic [15:0]  b_err_count;

    mux_n_pipe #(.DATA_WIDTH(8), .NUM_INPUTS(16), .ERR_CNT_WIDTH(16)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_src   (b_out_src),
        .out_err   (b_out_err),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .err_count (b_err_count)
    );

    // ---------------- scoreboard ----------------
    localparam int EW = 35;  // {err, src[1:0], data[31:0]}
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_a_words(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        a_in_data = {w2, w1, w0};
    endtask

    function automatic logic [7:0] b_word(input int k);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(k);
        lo = 4'(15 - k);
        return {hi, lo};
    endfunction

    function automatic logic [EW-1:0] a_model(input logic [95:0] d, input logic [1:0] s);
        if (s == 2'd3) return {1'b1, s, 32'h0};
        return {1'b0, s, d[32*s +: 32]};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int accepted;
        int cycles;
        logic [EW-1:0] exp_e;

        a_in_data = '0; a_in_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset values
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready",  a_in_ready,  1);
        chk("rst_out_data",  a_out_data,  0);
        chk("rst_out_src",   a_out_src,   0);
        chk("rst_out_err",   a_out_err,   0);
        chk("rst_err_count", a_err_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic select, latency one edge
        set_a_words(32'hAAAA0000, 32'h1111BBBB, 32'hCCCC2222);
        a_in_sel = 2'd2; a_in_valid = 1'b1; a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        chk("sel2_valid", a_out_valid, 1);
        chk("sel2_data",  a_out_data,  32'hCCCC2222);
        chk("sel2_src",   a_out_src,   2);
        chk("sel2_err",   a_out_err,   0);
        step();
        chk("sel2_drained", a_out_valid, 0);

        // Out-of-range select
        a_in_sel = 2'd3; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        chk("oor_valid", a_out_valid, 1);
        chk("oor_data",  a_out_data,  0);
        chk("oor_src",   a_out_src,   3);
        chk("oor_err",   a_out_err,   1);
        chk("oor_count", a_err_count, 1);
        step();

        // Saturation: back-to-back bad selects at one per cycle
        a_in_valid = 1'b1;
        for (int i = 0; i < 16'hFFFD; i++) step();
        chk("sat_count_fffe",  a_err_count, 16'hFFFE);
        chk("sat_in_ready",    a_in_ready,  1);
        step();
        chk("sat_count_ffff",  a_err_count, 16'hFFFF);
        for (int i = 0; i < 3; i++) step();
        chk("sat_count_hold",  a_err_count, 16'hFFFF);
        a_in_valid = 1'b0;
        step();
        chk("sat_drained", a_out_valid, 0);

        // Back-pressure: three offers, two accepted
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_sel = 2'd0;
        step();
        chk("bp1_data",     a_out_data, 32'hAAAA0000);
        chk("bp1_in_ready", a_in_ready, 1);
        a_in_sel = 2'd1;
        step();
        chk("bp2_in_ready", a_in_ready, 0);
        chk("bp2_data",     a_out_data, 32'hAAAA0000);
        chk("bp2_src",      a_out_src,  0);
        a_in_sel = 2'd2;
        step();
        chk("bp3_in_ready", a_in_ready,  0);
        chk("bp3_valid",    a_out_valid, 1);
        chk("bp3_data",     a_out_data,  32'hAAAA0000);
        a_out_ready = 1'b1;
        step();
        chk("bp_out1_data", a_out_data, 32'h1111BBBB);
        chk("bp_out1_src",  a_out_src,  1);
        chk("bp_out1_rdy",  a_in_ready, 1);
        step();
        a_in_valid = 1'b0;
        chk("bp_out2_data", a_out_data, 32'hCCCC2222);
        chk("bp_out2_src",  a_out_src,  2);
        step();
        chk("bp_empty", a_out_valid, 0);

        // Random stream against the FIFO model
        accepted = 0;
        cycles = 0;
        while ((accepted < 100 || exp_q.size() != 0) && cycles < 2000) begin
            a_in_valid  = (accepted < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            a_in_data   = {$urandom(), $urandom(), $urandom()};
            a_in_sel    = 2'($urandom_range(0, 3));
            a_out_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_in_ready",  a_in_ready,  exp_q.size() < 2);
            chk("rnd_out_valid", a_out_valid, exp_q.size() > 0);
            if (a_out_valid && a_out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_out", 1, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("rnd_entry", {a_out_err, a_out_src, a_out_data}, exp_e);
                end
            end
            if (a_in_valid && a_in_ready) begin
                exp_q.push_back(a_model(a_in_data, a_in_sel));
                accepted++;
            end
            step();
            cycles++;
        end
        chk("rnd_timeout", cycles < 2000, 1);
        chk("rnd_accepted", accepted, 100);
        a_in_valid = 1'b0;
        exp_q.delete();
        step();

        // Reset in the middle of a cycle while FULL
        set_a_words(32'hAAAA0000, 32'h1111BBBB, 32'hCCCC2222);
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_sel = 2'd3;
        step();
        a_in_sel = 2'd2;
        step();
        chk("full_in_ready", a_in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    a_out_valid, 0);
        chk("mid_rst_in_ready", a_in_ready,  1);
        chk("mid_rst_count",    a_err_count, 0);
        chk("mid_rst_data",     a_out_data,  0);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_no_stale", a_out_valid, 0);
        a_in_sel = 2'd1; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        chk("post_rst_data",  a_out_data,  32'h1111BBBB);
        chk("post_rst_count", a_err_count, 0);
        step();
        chk("post_rst_empty", a_out_valid, 0);

        // 16-input sweep on instance B
        for (int k = 0; k < 16; k++) b_in_data[k*8 +: 8] = b_word(k);
        b_out_ready = 1'b1;
        b_in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            b_in_sel = 4'(k);
            step();
            chk("b16_data",  b_out_data,  b_word(k));
            chk("b16_src",   b_out_src,   k);
            chk("b16_err",   b_out_err,   0);
            chk("b16_valid", b_out_valid, 1);
        end
        b_in_valid = 1'b0;
        step();
        chk("b16_count", b_err_count, 0);
        chk("b16_empty", b_out_valid, 0);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
